// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the MEM-stage load/store port.
// It accepts one request at a time over a valid/ready handshake. The RAM access
// happens LATENCY cycles after acceptance. The response is then held until the
// consumer takes it.
// Optional build macro: DMEM_MISALIGN_CHECK_EN. When it is defined, misaligned
// H/W accesses are flagged on rsp_err and perform no write. When it is not
// defined, misaligned accesses align down and rsp_err stays 0.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT_INIT = 4'(LATENCY);

    state_t state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;

    // Request fields captured on the accept edge.
    logic              lat_we;
    logic [2:0]        lat_funct3;
    logic [ADDR_W+1:0] lat_addr;
    logic [31:0]       lat_wdata;

    logic accept;
    logic access_en;

    // Fields that drive the RAM access. With zero latency the access happens on
    // the accept edge itself, so the live request is used in IDLE.
    logic              acc_we;
    logic [2:0]        acc_funct3;
    logic [ADDR_W+1:0] acc_addr;
    logic [31:0]       acc_wdata;
    logic [ADDR_W-1:0] acc_index;
    logic [1:0]        acc_lane;
    logic [1:0]        acc_size;
    logic              acc_unsigned;
    logic              acc_misaligned;

    logic [3:0]  byte_en;
    logic [31:0] wr_word;
    logic [31:0] rd_word;
    logic [31:0] load_data;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Address bits above the RAM index wrap and are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

    assign req_ready = (state_reg == IDLE) && !rst;
    assign rsp_valid = (state_reg == RESP);
    assign accept    = req_valid && req_ready;

    assign acc_we       = (state_reg == IDLE) ? req_we                 : lat_we;
    assign acc_funct3   = (state_reg == IDLE) ? req_funct3             : lat_funct3;
    assign acc_addr     = (state_reg == IDLE) ? req_addr[ADDR_W+1:0]   : lat_addr;
    assign acc_wdata    = (state_reg == IDLE) ? req_wdata              : lat_wdata;
    assign acc_index    = acc_addr[ADDR_W+1:2];
    assign acc_lane     = acc_addr[1:0];
    // funct3[1:0]: 00 byte, 01 half, 1x word (so 011/110/111 behave as word).
    assign acc_size     = acc_funct3[1:0];
    assign acc_unsigned = acc_funct3[2];

`ifdef DMEM_MISALIGN_CHECK_EN
    assign acc_misaligned = ((acc_size == 2'b01) && acc_lane[0]) ||
                            (acc_size[1] && (acc_lane != 2'b00));
`else
    assign acc_misaligned = 1'b0;
`endif

    // Byte enables and lane-replicated store data for the selected access size.
    always_comb begin
        byte_en = 4'b0000;
        wr_word = acc_wdata;
        case (acc_size)
            2'b00: begin
                byte_en[acc_lane] = 1'b1;
                wr_word = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                byte_en = acc_lane[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{acc_wdata[15:0]}};
            end
            default: begin
                byte_en = 4'b1111;
                wr_word = acc_wdata;
            end
        endcase
        if (acc_misaligned) begin
            byte_en = 4'b0000;
        end
    end

    // One byte-wide RAM per lane. The read result is registered in rsp_rdata.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] ram [DEPTH];

            // Byte-lane write on the edge that enters RESP.
            always_ff @(posedge clk) begin
                if (access_en && acc_we && byte_en[gi]) begin
                    ram[acc_index] <= wr_word[gi*8 +: 8];
                end
            end

            assign rd_word[gi*8 +: 8] = ram[acc_index];
        end
    endgenerate

    // Lane extraction with sign or zero extension for loads.
    always_comb begin
        sel_byte  = rd_word[{acc_lane, 3'b000} +: 8];
        sel_half  = acc_lane[1] ? rd_word[31:16] : rd_word[15:0];
        load_data = rd_word;
        case (acc_size)
            2'b00:   load_data = acc_unsigned ? {24'b0, sel_byte}
                                              : {{24{sel_byte[7]}}, sel_byte};
            2'b01:   load_data = acc_unsigned ? {16'b0, sel_half}
                                              : {{16{sel_half[15]}}, sel_half};
            default: load_data = rd_word;
        endcase
    end

    // Next-state logic for the FSM and the latency counter.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        access_en  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    cnt_next = LAT_INIT;
                    if (LATENCY == 0) begin
                        state_next = RESP;
                        access_en  = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg <= 4'd1) begin
                    cnt_next   = 4'd0;
                    state_next = RESP;
                    access_en  = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, request capture and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= 4'd0;
            lat_we     <= 1'b0;
            lat_funct3 <= 3'd0;
            lat_addr   <= '0;
            lat_wdata  <= 32'd0;
            rsp_rdata  <= 32'd0;
            rsp_err    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                lat_we     <= req_we;
                lat_funct3 <= req_funct3;
                lat_addr   <= req_addr[ADDR_W+1:0];
                lat_wdata  <= req_wdata;
            end
            if (access_en) begin
                rsp_rdata <= (acc_we || acc_misaligned) ? 32'd0 : load_data;
                rsp_err   <= acc_misaligned;
            end else if ((state_reg == RESP) && rsp_ready) begin
                rsp_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder (LATENCY=2, DEPTH=256).
// The expectations follow the DMEM_MISALIGN_CHECK_EN build setting.
module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    dmem_responder #(.DEPTH(256), .ADDR_W(8), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

`ifdef DMEM_MISALIGN_CHECK_EN
    localparam logic [31:0] EXP_LW6   = 32'h0000_0000;
    localparam logic        ERR_MIS   = 1'b1;
    localparam logic [31:0] EXP_FINAL = 32'h1234_80DD;
`else
    localparam logic [31:0] EXP_LW6   = 32'h1234_80DD;
    localparam logic        ERR_MIS   = 1'b0;
    localparam logic [31:0] EXP_FINAL = 32'h1234_BEEF;
`endif

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one request and wait for its response. The handshake completes here
    // only when rsp_ready is 1. The returned latency counts edges from the
    // accept edge (inclusive) to the edge that raises rsp_valid.
    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd,
                        output logic err, output int lat, output logic ok);
        logic was_ready;
        ok  = 1'b0;
        lat = 0;
        rd  = 32'd0;
        err = 1'b0;
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        for (int g = 0; g < 20; g++) begin
            was_ready = req_ready;
            @(posedge clk); #1;
            if (was_ready) begin
                ok = 1'b1;
                break;
            end
        end
        req_valid = 1'b0;
        // Scramble the request inputs to show they are only sampled on accept.
        req_we = ~we; req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
        if (ok) begin
            lat = 1;
            while (!rsp_valid && lat < 40) begin
                @(posedge clk); #1;
                lat++;
            end
            rd  = rsp_rdata;
            err = rsp_err;
            if (rsp_ready) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd, held;
        logic        err, ok;
        int          lat;

        vecs[0]  = '{1'b1, 3'b010, 32'h0000_0010, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b1, 3'b010, 32'h0000_0004, 32'hAABB_CCDD, 32'h0000_0000, 1'b0};
        vecs[2]  = '{1'b0, 3'b010, 32'h0000_0004, 32'h0000_0000, 32'hAABB_CCDD, 1'b0};
        vecs[3]  = '{1'b1, 3'b000, 32'h0000_0005, 32'h1234_5680, 32'h0000_0000, 1'b0};
        vecs[4]  = '{1'b1, 3'b001, 32'h0000_0006, 32'hDEAD_1234, 32'h0000_0000, 1'b0};
        vecs[5]  = '{1'b0, 3'b010, 32'h0000_0004, 32'h0000_0000, 32'h1234_80DD, 1'b0};
        vecs[6]  = '{1'b0, 3'b000, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FF80, 1'b0};
        vecs[7]  = '{1'b0, 3'b100, 32'h0000_0005, 32'h0000_0000, 32'h0000_0080, 1'b0};
        vecs[8]  = '{1'b0, 3'b001, 32'h0000_0006, 32'h0000_0000, 32'h0000_1234, 1'b0};
        vecs[9]  = '{1'b0, 3'b001, 32'h0000_0004, 32'h0000_0000, 32'hFFFF_80DD, 1'b0};
        vecs[10] = '{1'b0, 3'b101, 32'h0000_0004, 32'h0000_0000, 32'h0000_80DD, 1'b0};
        vecs[11] = '{1'b0, 3'b000, 32'h0000_0004, 32'h0000_0000, 32'hFFFF_FFDD, 1'b0};
        vecs[12] = '{1'b0, 3'b100, 32'h0000_0007, 32'h0000_0000, 32'h0000_0012, 1'b0};
        vecs[13] = '{1'b0, 3'b011, 32'h0000_0004, 32'h0000_0000, 32'h1234_80DD, 1'b0};
        vecs[14] = '{1'b1, 3'b010, 32'h0000_0408, 32'h5A5A_5A5A, 32'h0000_0000, 1'b0};
        vecs[15] = '{1'b0, 3'b010, 32'h0000_0008, 32'h0000_0000, 32'h5A5A_5A5A, 1'b0};
        vecs[16] = '{1'b0, 3'b010, 32'h0000_0006, 32'h0000_0000, EXP_LW6,       ERR_MIS};
        vecs[17] = '{1'b1, 3'b001, 32'h0000_0005, 32'h0000_BEEF, 32'h0000_0000, ERR_MIS};
        vecs[18] = '{1'b0, 3'b010, 32'h0000_0004, 32'h0000_0000, EXP_FINAL,     1'b0};
        vecs[19] = '{1'b0, 3'b101, 32'h0000_0006, 32'h0000_0000, 32'h0000_1234, 1'b0};

        // Reset state.
        #1;
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        check("reset_req_ready_held", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("post_reset_req_ready", 32'(req_ready), 32'd1);

        // Table-driven vectors, rsp_ready held at 1.
        for (int i = 0; i < NVEC; i++) begin
            xact(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, err, lat, ok);
            $display("vec %0d: we=%0d f3=%03b addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
                     i, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, err, lat);
            check($sformatf("vec%0d_accept", i), 32'(ok), 32'd1);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT + 1));
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_rsp_dropped", i), 32'(rsp_valid), 32'd0);
            check($sformatf("vec%0d_err_cleared", i), 32'(rsp_err), 32'd0);
        end

        // Backpressure: the response is held stable while rsp_ready is low.
        rsp_ready = 1'b0;
        xact(1'b0, 3'b010, 32'h0000_0004, 32'h0, rd, err, lat, ok);
        $display("backpressure: LW @4 -> rdata=%h lat=%0d", rd, lat);
        check("bp_latency", 32'(lat), 32'(LAT + 1));
        check("bp_rdata", rd, EXP_FINAL);
        held = rd;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp_valid_c%0d", c), 32'(rsp_valid), 32'd1);
            check($sformatf("bp_stable_c%0d", c), rsp_rdata, held);
            check($sformatf("bp_req_ready_c%0d", c), 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_done_valid", 32'(rsp_valid), 32'd0);
        check("bp_done_req_ready", 32'(req_ready), 32'd1);

        // Reset during WAIT: the pending store must not reach the RAM.
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'hFFFF_FFFF;
        req_valid = 1'b1;
        check("rst_mid_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst_mid_waiting", 32'(rsp_valid), 32'd0);
        rst = 1'b1;
        #1;
        check("rst_mid_req_ready", 32'(req_ready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("rst_mid_valid_c%0d", c), 32'(rsp_valid), 32'd0);
            check($sformatf("rst_mid_ready_c%0d", c), 32'(req_ready), 32'd0);
        end
        rst = 1'b0;
        #1;
        xact(1'b0, 3'b010, 32'h0000_0010, 32'h0, rd, err, lat, ok);
        $display("after reset: LW @0x10 -> rdata=%h lat=%0d", rd, lat);
        check("rst_mid_accept", 32'(ok), 32'd1);
        check("rst_mid_store_dropped", rd, 32'd0);
        xact(1'b0, 3'b010, 32'h0000_0004, 32'h0, rd, err, lat, ok);
        $display("after reset: LW @0x4 -> rdata=%h lat=%0d", rd, lat);
        check("rst_ram_kept", rd, EXP_FINAL);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
